// File: rtl/hex_display_mux_pkg.sv
// Shared constants for the seven-segment display driver: hex font and blank pattern.
// Glyphs are active-high segment patterns g..a (bit 6 = g, bit 0 = a).
package hex_display_mux_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;  // lowercase b
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;  // lowercase d
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/hex_display_mux_encoder.sv
// hex_encoder: one hex nibble to an active-low segment byte (bit 7 = dot).
// 'off' blanks the glyph only; the dot is controlled separately so a
// suppressed leading zero can still show its decimal point.
module hex_encoder
   import hex_display_mux_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       off,
   input  logic       dot,
   output logic [7:0] segments
);

   logic [6:0] glyph;

   // Font lookup
   always_comb begin
      glyph = GLYPH_0;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = GLYPH_0;
      endcase
   end

   assign segments = {~dot, (off ? 7'h7F : ~glyph)};

endmodule

// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed common-anode seven-segment driver.
// The scan counter (cnt, idx) names the output cycle being computed, so it
// runs one cycle ahead of the registered outputs. When it reads slot 0
// cycle 0, the display is showing the last cycle of the frame: that is the
// promotion point. The first output cycle of the new frame is dead time, so
// the new active contents are never seen half-applied.
module hex_display_mux
   import hex_display_mux_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1024,
   parameter int DEAD     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dots,
   input  logic                  blank_lz,
   input  logic                  load,
   input  logic                  enable,
   output logic [7:0]            segments,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;

   logic [4*DIGITS-1:0]   pend_value;
   logic [DIGITS-1:0]     pend_dots;
   logic                  pend_blank_lz;
   logic                  pend_valid;

   logic [4*DIGITS-1:0]   act_value;
   logic [DIGITS-1:0]     act_dots;
   logic                  act_blank_lz;

   logic                  boundary;
   logic                  dead;
   logic                  lit;
   logic                  lead;
   logic [DIGITS-1:0]     suppress;
   logic [3:0]            cur_nibble;
   logic                  cur_dot;
   logic                  cur_sup;
   logic                  enc_off;
   logic                  enc_dot;
   logic [7:0]            seg_next;
   logic [DIGITS-1:0]     en_next;

   assign boundary = (cnt == '0) && (idx == '0);
   assign dead     = (cnt < CW'(DEAD));
   assign lit      = enable && !dead;

   // Scan counter and digit index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CW'(SCAN_DIV - 1)) begin
         cnt <= '0;
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Pending capture and frame-boundary promotion. With nothing pending, a
   // load that lands on the boundary goes straight to active; with something
   // pending, the older data is promoted and the new load waits a frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_value    <= '0;
         pend_dots     <= '0;
         pend_blank_lz <= 1'b0;
         pend_valid    <= 1'b0;
         act_value     <= '0;
         act_dots      <= '0;
         act_blank_lz  <= 1'b0;
      end else begin
         if (boundary && pend_valid) begin
            act_value    <= pend_value;
            act_dots     <= pend_dots;
            act_blank_lz <= pend_blank_lz;
         end else if (boundary && load) begin
            act_value    <= value;
            act_dots     <= dots;
            act_blank_lz <= blank_lz;
         end
         if (load) begin
            pend_value    <= value;
            pend_dots     <= dots;
            pend_blank_lz <= blank_lz;
         end
         pend_valid <= boundary ? (pend_valid & load) : (pend_valid | load);
      end
   end

   // Leading-zero mask: walk down from the top digit until a nonzero nibble
   always_comb begin
      suppress = '0;
      lead     = act_blank_lz;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (lead && (act_value[4*k +: 4] == 4'h0)) begin
            suppress[k] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
   end

   // Select the current digit's nibble, dot and suppression; build digit drive
   always_comb begin
      cur_nibble = 4'h0;
      cur_dot    = 1'b0;
      cur_sup    = 1'b0;
      en_next    = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nibble = act_value[4*k +: 4];
            cur_dot    = act_dots[k];
            cur_sup    = suppress[k];
            en_next[k] = !lit;
         end
      end
   end

   assign enc_off = !enable || dead || cur_sup;
   assign enc_dot = cur_dot && !dead && enable;

   hex_encoder u_enc (
      .nibble   (cur_nibble),
      .off      (enc_off),
      .dot      (enc_dot),
      .segments (seg_next)
   );

   // Output registers; reset blanks the display immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         segments <= SEG_OFF;
         digit_en <= '1;
         frame    <= 1'b0;
      end else begin
         segments <= seg_next;
         digit_en <= en_next;
         frame    <= boundary;
      end
   end

endmodule
